// File: rtl/seq_det_pkg.sv
// Shared constants and types for the time-multiplexed 3-bit sequence detector.
package seq_det_pkg;

  localparam int unsigned N_CH_DEF    = 4;
  localparam int unsigned CH_W        = $clog2(N_CH_DEF);
  localparam logic [2:0]  PATTERN_DEF = 3'b100;
  localparam int unsigned CNT_W_DEF   = 8;
  localparam logic [1:0]  FILL_FULL   = 2'd2;

  // Per-channel detector context: two most recent bits (newest in [0]) and bits-seen count.
  typedef struct packed {
    logic [1:0] hist;
    logic [1:0] fill;
  } hist_t;

  function automatic logic [1:0] fill_inc(input logic [1:0] f);
    return (f >= FILL_FULL) ? FILL_FULL : f + 2'd1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or above ptr, wrapping mod N.
module rr_arbiter #(
  parameter int unsigned N = 4,
  parameter int unsigned W = $clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [N-1:0] gnt,
  output logic [W-1:0] gnt_idx,
  output logic         gnt_valid
);

  logic [W-1:0] cand;

  always_comb begin
    gnt       = '0;
    gnt_idx   = '0;
    gnt_valid = 1'b0;
    cand      = '0;
    for (int unsigned k = 0; k < N; k++) begin
      cand = W'((32'(ptr) + k) % N);
      if (!gnt_valid && req[cand]) begin
        gnt_valid = 1'b1;
        gnt_idx   = cand;
        gnt[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/shared_seq_det_sched.sv
// One 3-bit pattern detector shared round-robin across N_CH serial channels,
// with per-channel history so each channel behaves as an independent detector.
module shared_seq_det_sched
  import seq_det_pkg::*;
#(
  parameter int unsigned N_CH    = N_CH_DEF,
  parameter logic [2:0]  PATTERN = PATTERN_DEF,
  parameter int unsigned CNT_W   = CNT_W_DEF
) (
  input  logic                    Clk,
  input  logic                    Reset,
  input  logic [N_CH-1:0]         Req,
  input  logic [N_CH-1:0]         X,
  input  logic                    Clear,
  output logic [N_CH-1:0]         Gnt,
  output logic                    Match,
  output logic [$clog2(N_CH)-1:0] Match_ch,
  output logic [CNT_W-1:0]        Match_cnt
);

  localparam int unsigned CH_BITS = $clog2(N_CH);

  logic [CH_BITS-1:0] ptr;
  logic [CH_BITS-1:0] ptr_nxt;
  hist_t              st [N_CH];

  logic [N_CH-1:0]    arb_gnt;
  logic [CH_BITS-1:0] gi;
  logic               arb_valid;
  logic               block;
  logic               consume;
  logic [2:0]         seq;
  logic               hit;
  logic [CNT_W-1:0]   cnt_sat;

  rr_arbiter #(.N(N_CH), .W(CH_BITS)) u_arb (
    .req      (Req),
    .ptr      (ptr),
    .gnt      (arb_gnt),
    .gnt_idx  (gi),
    .gnt_valid(arb_valid)
  );

  // Reset and Clear both suppress the grant so the offered bit stays pending.
  assign block   = Reset | Clear;
  assign Gnt     = block ? '0 : arb_gnt;
  assign consume = arb_valid & ~block;

  always_comb begin
    seq     = {st[gi].hist, X[gi]};
    hit     = consume && (st[gi].fill == FILL_FULL) && (seq == PATTERN);
    ptr_nxt = (gi == CH_BITS'(N_CH - 1)) ? '0 : gi + 1'b1;
    cnt_sat = (Match_cnt == '1) ? Match_cnt : Match_cnt + 1'b1;
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      ptr       <= '0;
      for (int unsigned i = 0; i < N_CH; i++) st[i] <= '0;
      Match     <= 1'b0;
      Match_ch  <= '0;
      Match_cnt <= '0;
    end else if (Clear) begin
      for (int unsigned i = 0; i < N_CH; i++) st[i] <= '0;
      Match     <= 1'b0;
      Match_cnt <= '0;
    end else begin
      Match <= hit;
      if (consume) begin
        ptr         <= ptr_nxt;
        st[gi].hist <= {st[gi].hist[0], X[gi]};
        st[gi].fill <= fill_inc(st[gi].fill);
      end
      if (hit) begin
        Match_ch  <= gi;
        Match_cnt <= cnt_sat;
      end
    end
  end

endmodule

// File: tb/tb_shared_seq_det_sched.sv
// Randomized and directed bench for shared_seq_det_sched; two instances (PATTERN=100/CNT_W=8
// and PATTERN=000/CNT_W=2) share stimulus and are checked against a queue-based model.
module tb_shared_seq_det_sched;

  localparam int N = 4;

  logic       Clk = 1'b0;
  logic       Reset, Clear;
  logic [3:0] Req, X;
  logic [3:0] gnt_a, gnt_b;
  logic       match_a, match_b;
  logic [1:0] mch_a, mch_b;
  logic [7:0] cnt_a;
  logic [1:0] cnt_b;

  shared_seq_det_sched #(.N_CH(4), .PATTERN(3'b100), .CNT_W(8)) dut_a (
    .Clk(Clk), .Reset(Reset), .Req(Req), .X(X), .Clear(Clear),
    .Gnt(gnt_a), .Match(match_a), .Match_ch(mch_a), .Match_cnt(cnt_a)
  );

  shared_seq_det_sched #(.N_CH(4), .PATTERN(3'b000), .CNT_W(2)) dut_b (
    .Clk(Clk), .Reset(Reset), .Req(Req), .X(X), .Clear(Clear),
    .Gnt(gnt_b), .Match(match_b), .Match_ch(mch_b), .Match_cnt(cnt_b)
  );

  always #5 Clk = ~Clk;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: per instance, per channel, the last up-to-3 bits received since reset/Clear.
  bit         mq [2][N][$];
  logic [2:0] m_pat [2] = '{3'b100, 3'b000};
  int         m_max [2] = '{255, 3};
  int         m_ptr;
  bit         m_match [2];
  int         m_ch [2];
  int         m_cnt [2];

  task automatic step(input logic [3:0] rq, input logic [3:0] xv, input logic clr,
                      input logic rst, output int g);
    logic [3:0] eg;
    logic [2:0] s;
    Req = rq; X = xv; Clear = clr; Reset = rst;
    #1;
    g = -1;
    if (!rst && !clr)
      for (int k = 0; k < N; k++)
        if (g < 0 && rq[(m_ptr + k) % N]) g = (m_ptr + k) % N;
    eg = (g < 0) ? 4'b0000 : 4'(1 << g);
    check("gnt_a", 32'(gnt_a), 32'(eg));
    check("gnt_b", 32'(gnt_b), 32'(eg));
    for (int i = 0; i < 2; i++) begin
      if (rst || clr) begin
        for (int c = 0; c < N; c++) mq[i][c].delete();
        m_match[i] = 0;
        m_cnt[i]   = 0;
        if (rst) m_ch[i] = 0;
      end else if (g >= 0) begin
        mq[i][g].push_back(xv[g]);
        if (mq[i][g].size() > 3) void'(mq[i][g].pop_front());
        s = 3'b000;
        if (mq[i][g].size() == 3) s = {mq[i][g][0], mq[i][g][1], mq[i][g][2]};
        m_match[i] = (mq[i][g].size() == 3) && (s == m_pat[i]);
        if (m_match[i]) begin
          m_ch[i]  = g;
          m_cnt[i] = (m_cnt[i] < m_max[i]) ? m_cnt[i] + 1 : m_cnt[i];
        end
      end else begin
        m_match[i] = 0;
      end
    end
    if (rst) m_ptr = 0;
    else if (g >= 0) m_ptr = (g + 1) % N;
    @(posedge Clk);
    #1;
    check("match_a", 32'(match_a), 32'(m_match[0]));
    check("mch_a",   32'(mch_a),   32'(m_ch[0]));
    check("cnt_a",   32'(cnt_a),   32'(m_cnt[0]));
    check("match_b", 32'(match_b), 32'(m_match[1]));
    check("mch_b",   32'(mch_b),   32'(m_ch[1]));
    check("cnt_b",   32'(cnt_b),   32'(m_cnt[1]));
    @(negedge Clk);
  endtask

  task automatic send(input int ch, input logic b, output int g);
    step(4'(1 << ch), 4'(b) << ch, 1'b0, 1'b0, g);
  endtask

  task automatic do_reset();
    int g;
    step(4'b1111, 4'b0000, 1'b0, 1'b1, g);
  endtask

  initial begin
    int g;
    int pulses;
    logic [3:0] pr, px;
    Req = '0; X = '0; Clear = 1'b0; Reset = 1'b1;
    m_ptr = 0;
    @(negedge Clk);
    do_reset();
    check("rst_match", 32'(match_a), 32'd0);
    check("rst_cnt",   32'(cnt_a),   32'd0);

    // ch0 sends 1,0,0: match one cycle after third grant
    send(0, 1'b1, g); send(0, 1'b0, g); send(0, 1'b0, g);
    check("t1_match", 32'(match_a), 32'd1);
    check("t1_ch",    32'(mch_a),   32'd0);
    check("t1_cnt",   32'(cnt_a),   32'd1);

    // all requesting: grants rotate 0,1,2,3,0
    do_reset();
    for (int k = 0; k < 5; k++) begin
      step(4'b1111, 4'b0000, 1'b0, 1'b0, g);
      check("t2_gidx", 32'(g), 32'(k % 4));
    end

    // interleaved ch1/ch2 histories stay independent
    do_reset();
    send(1, 1'b1, g); send(2, 1'b0, g); send(1, 1'b0, g); send(2, 1'b0, g);
    check("t3_nomatch", 32'(match_a), 32'd0);
    send(1, 1'b0, g);
    check("t3_match", 32'(match_a), 32'd1);
    check("t3_ch",    32'(mch_a),   32'd1);
    check("t3_cnt",   32'(cnt_a),   32'd1);

    // PATTERN=000: two zeros are not enough, the third matches
    do_reset();
    send(3, 1'b0, g); send(3, 1'b0, g);
    check("t4_early", 32'(match_b), 32'd0);
    send(3, 1'b0, g);
    check("t4_match", 32'(match_b), 32'd1);
    check("t4_ch",    32'(mch_b),   32'd3);

    // Clear in mid-sequence discards history and blocks the grant
    do_reset();
    send(0, 1'b1, g); send(0, 1'b0, g);
    step(4'b0001, 4'b0000, 1'b1, 1'b0, g);
    check("t5_gnt_clr", 32'(g), 32'hFFFF_FFFF);
    send(0, 1'b0, g);
    check("t5_nomatch", 32'(match_a), 32'd0);
    check("t5_cnt",     32'(cnt_a),   32'd0);

    // 7 zeros on ch2: 5 overlapping matches, 2-bit counter saturates at 3
    do_reset();
    pulses = 0;
    for (int k = 0; k < 7; k++) begin
      send(2, 1'b0, g);
      if (match_b) pulses++;
    end
    check("t6_pulses", 32'(pulses), 32'd5);
    check("t6_cnt",    32'(cnt_b),  32'd3);

    // 8-bit counter saturation: 260 matches of 100 on ch0
    do_reset();
    for (int k = 0; k < 260; k++) begin
      send(0, 1'b1, g); send(0, 1'b0, g); send(0, 1'b0, g);
    end
    check("sat_match", 32'(match_a), 32'd1);
    check("sat_cnt",   32'(cnt_a),   32'd255);

    // random traffic; pending requesters hold Req/X until granted
    do_reset();
    pr = '0; px = '0;
    for (int k = 0; k < 3000; k++) begin
      for (int c = 0; c < N; c++)
        if (!pr[c]) begin
          pr[c] = ($urandom_range(0, 1) == 1);
          px[c] = ($urandom_range(0, 2) == 0);
        end
      step(pr, px, ($urandom_range(0, 47) == 0), ($urandom_range(0, 255) == 0), g);
      if (g >= 0) pr[g] = 1'b0;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
